// File: rtl/board_writer.sv
`timescale 1ns/1ps
// board_writer
// Write controller for the board RAM. Clears the whole board after reset or on
// request, places ships as runs of cells (data 1), and sets single cells to a
// given code. Commands arrive over a valid/ready handshake and are turned into
// one-cell-per-cycle writes on the memory write port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             full-board clear request (honoured in IDLE only)
//   cmd_valid/ready   command handshake (cmd_ready decoded from state and clear)
//   cmd_op            0 = place ship, 1 = set single cell
//   cmd_x, cmd_y      start column / row
//   cmd_len, cmd_vert ship length and orientation (place only)
//   cmd_data          cell code (set only)
//   busy              high whenever not IDLE
//   done, error       one-cycle completion / rejection pulses
//   write_addr/data/enable  registered write port to board_mem, address {y, x}
module board_writer #(
  parameter int X_SIZE       = 16,
  parameter int Y_SIZE       = 16,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter int MAX_SHIP_LEN = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_op,
  input  logic [X_ADDR_WIDTH-1:0]            cmd_x,
  input  logic [Y_ADDR_WIDTH-1:0]            cmd_y,
  input  logic [2:0]                         cmd_len,
  input  logic                               cmd_vert,
  input  logic [DATA_WIDTH-1:0]              cmd_data,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]              write_data,
  output logic                               write_enable
);

  localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH;
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]             CELLS    = CW'(X_SIZE * Y_SIZE);
  localparam logic [2:0]                MAX_LEN  = 3'(MAX_SHIP_LEN);
  localparam logic [X_ADDR_WIDTH:0]     X_LIM    = (X_ADDR_WIDTH+1)'(X_SIZE);
  localparam logic [Y_ADDR_WIDTH:0]     Y_LIM    = (Y_ADDR_WIDTH+1)'(Y_SIZE);
  localparam logic [AW-1:0]             ROW_STEP = AW'(X_SIZE);
  localparam logic [AW-1:0]             COL_STEP = AW'(1);
  localparam logic [DATA_WIDTH-1:0]     SHIP     = DATA_WIDTH'(1);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_PLACE, ST_SET} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;     // cells already issued in the current run
  logic [2:0]        len_q, len_d;
  logic              vert_q, vert_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Bounds are formed one bit wider than the coordinates so x+len cannot wrap.
  function automatic logic place_ok(input logic [X_ADDR_WIDTH-1:0] x,
                                    input logic [Y_ADDR_WIDTH-1:0] y,
                                    input logic [2:0] len,
                                    input logic vert);
    logic [X_ADDR_WIDTH:0] x_end;
    logic [Y_ADDR_WIDTH:0] y_end;
    x_end = {1'b0, x} + (X_ADDR_WIDTH+1)'(len);
    y_end = {1'b0, y} + (Y_ADDR_WIDTH+1)'(len);
    place_ok = (len != 3'd0) && (len <= MAX_LEN) &&
               (vert ? (y_end <= Y_LIM) : (x_end <= X_LIM));
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    vert_d    = vert_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    cmd_ready = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (cnt_q != CELLS) begin
          we_d   = 1'b1;
          addr_d = cnt_q[AW-1:0];
          data_d = '0;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_IDLE: begin
        cmd_ready = !clear;
        if (clear) begin
          // First cell is issued on the same edge so the clear takes exactly
          // X_SIZE*Y_SIZE write cycles, as after reset.
          state_d = ST_CLEAR;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = '0;
          cnt_d   = CW'(1);
        end else if (cmd_valid) begin
          if (cmd_op) begin
            state_d = ST_SET;
            we_d    = 1'b1;
            addr_d  = {cmd_y, cmd_x};
            data_d  = cmd_data;
          end else if (place_ok(cmd_x, cmd_y, cmd_len, cmd_vert)) begin
            state_d = ST_PLACE;
            we_d    = 1'b1;
            addr_d  = {cmd_y, cmd_x};
            data_d  = SHIP;
            len_d   = cmd_len;
            vert_d  = cmd_vert;
            cnt_d   = CW'(1);
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ST_PLACE: begin
        if (cnt_q != CW'(len_q)) begin
          we_d   = 1'b1;
          addr_d = addr_q + (vert_q ? ROW_STEP : COL_STEP);
          cnt_d  = cnt_q + CW'(1);
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_SET: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: state_d = ST_CLEAR;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      len_q   <= '0;
      vert_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      vert_q  <= vert_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;

endmodule

// File: tb/tb_board_writer.sv
`timescale 1ns/1ps
module tb_board_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [3:0] cmd_x = '0;
  logic [3:0] cmd_y = '0;
  logic [2:0] cmd_len = '0;
  logic       cmd_vert = 1'b0;
  logic [1:0] cmd_data = '0;
  logic       cmd_ready, busy, done, error, write_enable;
  logic [7:0] write_addr;
  logic [1:0] write_data;

  board_writer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len), .cmd_vert(cmd_vert),
    .cmd_data(cmd_data), .busy(busy), .done(done), .error(error),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [7:0] addr; logic [1:0] data;} wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic       op;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] len;
    logic       vert;
    logic [1:0] data;
    logic       exp_err;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard side: pop the next expected write and compare.
  task automatic expect_write(input string tag);
    wr_t e;
    chk({tag, "_we"}, write_enable, 1);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got write to %0h with no expected entry", tag, write_addr);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, write_addr, e.addr);
      chk({tag, "_data"}, write_data, e.data);
    end
  endtask

  // Reference model: expected write sequence for one accepted command.
  task automatic push_model(input logic op, input logic [3:0] x, input logic [3:0] y,
                            input logic [2:0] len, input logic vert, input logic [1:0] data);
    logic [7:0] a;
    if (op) exp_q.push_back({{y, x}, data});
    else begin
      for (int i = 0; i < int'(len); i++) begin
        a = {y, x} + 8'(i) * (vert ? 8'd16 : 8'd1);
        exp_q.push_back({a, 2'd1});
      end
    end
  endtask

  task automatic set_cmd(input logic op, input logic [3:0] x, input logic [3:0] y,
                         input logic [2:0] len, input logic vert, input logic [1:0] data);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_len = len; cmd_vert = vert; cmd_data = data;
  endtask

  // Present a command and return just after the accepting edge.
  task automatic drive_cmd(input logic op, input logic [3:0] x, input logic [3:0] y,
                           input logic [2:0] len, input logic vert, input logic [1:0] data);
    int budget;
    @(negedge clk);
    set_cmd(op, x, y, len, vert, data);
    cmd_valid = 1'b1;
    #1;
    budget = 0;
    while (!cmd_ready && budget < 400) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_op(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      expect_write(tag);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done_early"}, done, 0);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_we_after"}, write_enable, 0);
    chk({tag, "_ready_at_done"}, cmd_ready, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_err_at_done"}, error, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic expect_reject(input string tag);
    @(negedge clk);
    chk({tag, "_error"}, error, 1);
    chk({tag, "_we"}, write_enable, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_done"}, done, 0);
    @(negedge clk);
    chk({tag, "_error_pulse"}, error, 0);
    chk({tag, "_we2"}, write_enable, 0);
  endtask

  // Full-board clear: 256 consecutive writes of 0, then done.
  task automatic run_clear(input string tag);
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 2'd0});
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      expect_write(tag);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_ready"}, cmd_ready, 0);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_we_after"}, write_enable, 0);
    chk({tag, "_ready_at_done"}, cmd_ready, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'd3,  4'd5,  3'd4, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'd15, 4'd12, 3'd4, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'd14, 4'd0,  3'd3, 1'b0, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 4'd0,  4'd13, 3'd4, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 4'd2,  4'd2,  3'd0, 1'b0, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 4'd2,  4'd2,  3'd5, 1'b0, 2'd0, 1'b1};
    vecs[6]  = '{1'b1, 4'd7,  4'd2,  3'd0, 1'b0, 2'd3, 1'b0};
    vecs[7]  = '{1'b0, 4'd12, 4'd0,  3'd4, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 4'd13, 4'd13, 3'd3, 1'b1, 2'd0, 1'b0};
    vecs[9]  = '{1'b0, 4'd15, 4'd0,  3'd2, 1'b0, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 4'd1,  4'd1,  3'd7, 1'b1, 2'd0, 1'b1};
    vecs[11] = '{1'b1, 4'd0,  4'd15, 3'd0, 1'b0, 2'd2, 1'b0};

    // Reset state
    #12;
    chk("rst_we", write_enable, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("init_clear");

    // Table-driven commands
    foreach (vecs[i]) begin
      if (!vecs[i].exp_err)
        push_model(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].len, vecs[i].vert, vecs[i].data);
      drive_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].len, vecs[i].vert, vecs[i].data);
      if (vecs[i].exp_err) expect_reject($sformatf("vec%0d", i));
      else finish_op(vecs[i].op ? 1 : int'(vecs[i].len), $sformatf("vec%0d", i));
    end

    // Back-to-back: set then place, place write starts right after done
    @(negedge clk);
    set_cmd(1'b1, 4'd7, 4'd2, 3'd0, 1'b0, 2'd3);
    cmd_valid = 1'b1;
    push_model(1'b1, 4'd7, 4'd2, 3'd0, 1'b0, 2'd3);
    #1 chk("b2b_ready0", cmd_ready, 1);
    @(posedge clk); #1;
    set_cmd(1'b0, 4'd3, 4'd5, 3'd4, 1'b0, 2'd0);
    push_model(1'b0, 4'd3, 4'd5, 3'd4, 1'b0, 2'd0);
    @(negedge clk);
    expect_write("b2b_set");
    chk("b2b_ready_busy", cmd_ready, 0);
    @(negedge clk);
    chk("b2b_set_done", done, 1);
    chk("b2b_set_we_off", write_enable, 0);
    chk("b2b_ready_at_done", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish_op(4, "b2b_place");

    // clear and cmd_valid together: clear wins, command waits
    @(negedge clk);
    set_cmd(1'b1, 4'd1, 4'd1, 3'd0, 1'b0, 2'd2);
    cmd_valid = 1'b1;
    clear = 1'b1;
    #1 chk("clr_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    run_clear("req_clear");
    push_model(1'b1, 4'd1, 4'd1, 3'd0, 1'b0, 2'd2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish_op(1, "held_set");

    // clear pulsed during PLACE is ignored
    push_model(1'b0, 4'd8, 4'd9, 3'd4, 1'b1, 2'd0);
    drive_cmd(1'b0, 4'd8, 4'd9, 3'd4, 1'b1, 2'd0);
    clear = 1'b1;
    @(negedge clk); expect_write("clr_in_place");
    @(negedge clk); expect_write("clr_in_place");
    clear = 1'b0;
    finish_op(2, "clr_in_place");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("clr_ignored_we", write_enable, 0);
      chk("clr_ignored_busy", busy, 0);
    end

    // Reset during the third write of a len=4 place
    push_model(1'b0, 4'd0, 4'd4, 3'd4, 1'b0, 2'd0);
    drive_cmd(1'b0, 4'd0, 4'd4, 3'd4, 1'b0, 2'd0);
    @(negedge clk); expect_write("abort");
    @(negedge clk); expect_write("abort");
    @(negedge clk); expect_write("abort");
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", write_enable, 0);
    chk("abort_addr", write_addr, 0);
    chk("abort_data", write_data, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_busy", busy, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("abort_clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
